// File: rtl/rf_seq_pkg.sv
// Shared types for the register-file access sequencer: FSM encoding and
// the r_or_w direction constants of the single-port register file.
package rf_seq_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_A     = 3'd1,
    RD_B     = 3'd2,
    OPND     = 3'd3,
    WAIT_RES = 3'd4,
    WB       = 3'd5
  } rf_state_e;

  localparam logic RF_READ  = 1'b0;
  localparam logic RF_WRITE = 1'b1;

endpackage

// File: rtl/rf_access_seq.sv
// Serialises operand reads, operand hand-off and result write-back onto the
// single port of the register file for one three-address operation at a time.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. valid, once raised, is held with its payload until that edge;
// ready never depends combinationally on valid.
module rf_access_seq
  import rf_seq_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int REG_NUM = 16,
  parameter int ADDR_W  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [ADDR_W-1:0]  req_src_a,
  input  logic [ADDR_W-1:0]  req_src_b,
  input  logic [ADDR_W-1:0]  req_dst,
  input  logic               req_wb,
  output logic               rf_en,
  output logic               r_or_w,
  output logic [REG_NUM-1:0] reg_addr,
  output logic [WIDTH-1:0]   rf_wdata,
  input  logic [WIDTH-1:0]   rf_rdata,
  output logic               op_valid,
  input  logic               op_ready,
  output logic [WIDTH-1:0]   op_a,
  output logic [WIDTH-1:0]   op_b,
  output logic [ADDR_W-1:0]  op_dst,
  input  logic               res_valid,
  output logic               res_ready,
  input  logic [WIDTH-1:0]   res_data,
  output logic               busy,
  output logic [2:0]         state_dbg
);

  rf_state_e         state, next_state;
  logic [ADDR_W-1:0] src_a_q, src_b_q, dst_q;
  logic              wb_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      src_a_q  <= '0;
      src_b_q  <= '0;
      dst_q    <= '0;
      wb_q     <= 1'b0;
      op_a     <= '0;
      op_b     <= '0;
      rf_wdata <= '0;
    end else begin
      state <= next_state;
      case (state)
        IDLE: begin
          if (req_valid) begin
            src_a_q <= req_src_a;
            src_b_q <= req_src_b;
            dst_q   <= req_dst;
            wb_q    <= req_wb;
          end
        end
        // rf_rdata is only driven by the file while a read is enabled.
        RD_A:     op_a <= rf_rdata;
        RD_B:     op_b <= rf_rdata;
        WAIT_RES: if (res_valid) rf_wdata <= res_data;
        default:  ;
      endcase
    end
  end

  always_comb begin
    next_state = state;
    req_ready  = 1'b0;
    rf_en      = 1'b0;
    r_or_w     = RF_READ;
    reg_addr   = '0;
    op_valid   = 1'b0;
    res_ready  = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) next_state = RD_A;
      end
      RD_A: begin
        rf_en      = 1'b1;
        reg_addr   = REG_NUM'(src_a_q);
        next_state = RD_B;
      end
      RD_B: begin
        rf_en      = 1'b1;
        reg_addr   = REG_NUM'(src_b_q);
        next_state = OPND;
      end
      OPND: begin
        op_valid = 1'b1;
        if (op_ready) next_state = wb_q ? WAIT_RES : IDLE;
      end
      WAIT_RES: begin
        res_ready = 1'b1;
        if (res_valid) next_state = WB;
      end
      WB: begin
        rf_en      = 1'b1;
        r_or_w     = RF_WRITE;
        reg_addr   = REG_NUM'(dst_q);
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  assign op_dst    = dst_q;
  assign busy      = (state != IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_rf_access_seq.sv
// Directed bench for rf_access_seq with a behavioural 16x16 register file
// model and a write-back scoreboard keyed on {address, data}.
module tb_rf_access_seq;

  localparam int WIDTH   = 16;
  localparam int REG_NUM = 16;
  localparam int ADDR_W  = 4;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               req_valid = 1'b0;
  logic               req_ready;
  logic [ADDR_W-1:0]  req_src_a = '0;
  logic [ADDR_W-1:0]  req_src_b = '0;
  logic [ADDR_W-1:0]  req_dst = '0;
  logic               req_wb = 1'b0;
  logic               rf_en;
  logic               r_or_w;
  logic [REG_NUM-1:0] reg_addr;
  logic [WIDTH-1:0]   rf_wdata;
  wire  [WIDTH-1:0]   rf_rdata;
  logic               op_valid;
  logic               op_ready = 1'b0;
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic [ADDR_W-1:0]  op_dst;
  logic               res_valid = 1'b0;
  logic               res_ready;
  logic [WIDTH-1:0]   res_data = '0;
  logic               busy;
  logic [2:0]         state_dbg;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  // register file model: combinational read, write on the rising edge
  logic [WIDTH-1:0]  rf_mem [REG_NUM];
  logic              pl_en = 1'b0;
  logic [ADDR_W-1:0] pl_addr = '0;
  logic [WIDTH-1:0]  pl_data = '0;

  assign rf_rdata = (rf_en && !r_or_w) ? rf_mem[reg_addr[ADDR_W-1:0]] : 16'hzzzz;

  always @(posedge clk) begin
    if (pl_en) rf_mem[pl_addr] <= pl_data;
    else if (rf_en && r_or_w) rf_mem[reg_addr[ADDR_W-1:0]] <= rf_wdata;
  end

  rf_access_seq #(.WIDTH(WIDTH), .REG_NUM(REG_NUM), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_src_a (req_src_a),
    .req_src_b (req_src_b),
    .req_dst   (req_dst),
    .req_wb    (req_wb),
    .rf_en     (rf_en),
    .r_or_w    (r_or_w),
    .reg_addr  (reg_addr),
    .rf_wdata  (rf_wdata),
    .rf_rdata  (rf_rdata),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .op_dst    (op_dst),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [ADDR_W-1:0] a, input logic [WIDTH-1:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    tick();
    pl_en = 1'b0;
  endtask

  task automatic send_req(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b,
                          input logic [ADDR_W-1:0] d, input logic wb);
    req_valid = 1'b1; req_src_a = a; req_src_b = b; req_dst = d; req_wb = wb;
  endtask

  task automatic check_idle_zero(input string tag);
    check_eq({tag, "_state"}, 32'(state_dbg), 32'd0);
    check_eq({tag, "_outs"},
             {20'd0, rf_en, r_or_w, op_valid, res_ready, busy, req_ready, 6'd0},
             {20'd0, 6'b000001, 6'd0});
    check_eq({tag, "_addr_wdata"}, {reg_addr, rf_wdata}, 32'd0);
    check_eq({tag, "_op_ab"}, {op_a, op_b}, 32'd0);
    check_eq({tag, "_op_dst"}, 32'(op_dst), 32'd0);
  endtask

  // scoreboard: every write cycle must match the head of exp_q
  always @(negedge clk) begin
    if (rf_en && r_or_w) begin
      logic [31:0] exp_w;
      exp_w = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
      check_eq("rf_write", {reg_addr, rf_wdata}, exp_w);
    end
  end

  initial begin
    // reset
    rst = 1'b1;
    tick(); tick();
    check_idle_zero("reset");
    rst = 1'b0;
    preload(4'd3, 16'h1234);
    preload(4'd7, 16'h00FF);
    preload(4'd5, 16'hBEEF);
    preload(4'd10, 16'h5555);

    // basic wb=1 transaction, op_ready already high beforehand
    op_ready = 1'b1;
    exp_q.push_back({16'd9, 16'h1333});
    send_req(4'd3, 4'd7, 4'd9, 1'b1);
    tick();                                   // cycle 1
    req_valid = 1'b0;
    check_eq("t1_rd_a", {15'd0, rf_en, r_or_w, reg_addr}, {15'd0, 1'b1, 1'b0, 16'd3});
    tick();                                   // cycle 2
    check_eq("t1_rd_b", {15'd0, rf_en, r_or_w, reg_addr}, {15'd0, 1'b1, 1'b0, 16'd7});
    tick();                                   // cycle 3
    check_eq("t1_opnd_valid", {30'd0, op_valid, req_ready}, {30'd0, 1'b1, 1'b0});
    check_eq("t1_op_ab", {op_a, op_b}, {16'h1234, 16'h00FF});
    check_eq("t1_op_dst", 32'(op_dst), 32'd9);
    tick();                                   // cycle 4
    check_eq("t1_res_ready", 32'(res_ready), 32'd1);
    res_valid = 1'b1; res_data = 16'h1333;
    tick();                                   // cycle 5
    res_valid = 1'b0; res_data = '0;
    check_eq("t1_wb_ctl", {14'd0, rf_en, r_or_w, reg_addr}, {14'd0, 1'b1, 1'b1, 16'd9});
    check_eq("t1_wb_data", 32'(rf_wdata), 32'h1333);
    tick();                                   // cycle 6
    check_eq("t1_back_idle", {30'd0, busy, req_ready}, {30'd0, 1'b0, 1'b1});
    check_eq("t1_r9", 32'(rf_mem[9]), 32'h1333);

    // wb=0, then back-to-back request with src_a == src_b
    send_req(4'd3, 4'd7, 4'd2, 1'b0);
    tick();                                   // cycle 1
    req_valid = 1'b0;
    tick(); tick();                           // cycle 3: OPND, handshake at next edge
    check_eq("t2_opnd", 32'(op_valid), 32'd1);
    tick();                                   // cycle 4
    check_eq("t2_idle_after_op", {30'd0, busy, req_ready}, {30'd0, 1'b0, 1'b1});
    send_req(4'd5, 4'd5, 4'd0, 1'b0);
    tick();                                   // next request accepted at this edge
    req_valid = 1'b0;
    check_eq("t4_rd_a", {15'd0, rf_en, r_or_w, reg_addr}, {15'd0, 1'b1, 1'b0, 16'd5});
    tick();
    check_eq("t4_rd_b", {15'd0, rf_en, r_or_w, reg_addr}, {15'd0, 1'b1, 1'b0, 16'd5});
    tick();
    check_eq("t4_op_ab", {op_a, op_b}, {16'hBEEF, 16'hBEEF});
    tick();
    check_eq("t4_idle", 32'(busy), 32'd0);

    // op_ready backpressure for 10 cycles
    op_ready = 1'b0;
    send_req(4'd7, 4'd3, 4'd1, 1'b0);
    tick();
    req_valid = 1'b0;
    tick(); tick();
    for (int i = 0; i < 10; i++) begin
      check_eq("t3_hold_ctl", {28'd0, op_valid, rf_en, req_ready, busy},
               {28'd0, 1'b1, 1'b0, 1'b0, 1'b1});
      check_eq("t3_hold_ab", {op_a, op_b}, {16'h00FF, 16'h1234});
      tick();
    end
    op_ready = 1'b1;
    tick();
    check_eq("t3_release", {30'd0, busy, op_valid}, 32'd0);

    // reset while waiting for the result
    send_req(4'd3, 4'd7, 4'd10, 1'b1);
    tick();
    req_valid = 1'b0;
    tick(); tick(); tick();                   // cycle 4: WAIT_RES
    check_eq("t5_wait_res", {29'd0, state_dbg}, 32'd4);
    rst = 1'b1; res_valid = 1'b1; res_data = 16'hAAAA;
    tick();
    check_idle_zero("t5_mid_reset");
    rst = 1'b0;
    tick();                                   // res_valid still high, ignored in IDLE
    res_valid = 1'b0; res_data = '0;
    check_eq("t5_still_idle", 32'(state_dbg), 32'd0);
    check_eq("t5_r10", 32'(rf_mem[10]), 32'h5555);

    // stray result during RD_B must be ignored
    exp_q.push_back({16'd11, 16'h0042});
    send_req(4'd5, 4'd3, 4'd11, 1'b1);
    tick();                                   // cycle 1
    req_valid = 1'b0;
    tick();                                   // cycle 2: RD_B
    res_valid = 1'b1; res_data = 16'hDEAD;
    tick();                                   // cycle 3: OPND
    res_valid = 1'b0; res_data = '0;
    check_eq("t6_opnd", 32'(op_valid), 32'd1);
    tick();                                   // cycle 4: WAIT_RES
    res_valid = 1'b1; res_data = 16'h0042;
    tick();                                   // cycle 5: WB
    res_valid = 1'b0; res_data = '0;
    check_eq("t6_wb_data", 32'(rf_wdata), 32'h0042);
    tick();
    check_eq("t6_r11", 32'(rf_mem[11]), 32'h0042);

    // final report
    check_eq("wb_queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
